// File: rtl/dff_syncasync_reset.sv
`timescale 1ns/10ps
// D flip-flop with an asynchronous active-low reset and a synchronous active-high reset.
// Define DFF_RST_SYNC_EN to release the async reset through a 2-flop synchroniser on clk.
module dff_syncasync_reset #(
  parameter int unsigned      WIDTH         = 1,
  parameter logic [WIDTH-1:0] ASYNC_RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SYNC_RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic             arst_n_int;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

`ifdef DFF_RST_SYNC_EN
  logic [1:0] rst_sync_q;

  // Assertion is immediate; release ripples through two clk edges.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign arst_n_int = rst_sync_q[1];
`else
  assign arst_n_int = async_reset;
`endif

  // Ternary select lets an X on sync_reset reach q rather than being masked.
  always_comb begin
    q_d = sync_reset ? SYNC_RST_VAL : d;
  end

  always_ff @(posedge clk or negedge arst_n_int) begin
    if (!arst_n_int) begin
      q_q <= ASYNC_RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_syncasync_reset.sv
`timescale 1ns/10ps
// Directed bench for dff_syncasync_reset: three instances (default, SYNC_RST_VAL=1, 8-bit)
// sharing clock and resets; honours DFF_RST_SYNC_EN for release latency.
module tb_dff_syncasync_reset;

`ifdef DFF_RST_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [7:0] A8 = 8'h5A;
  localparam logic [7:0] S8 = 8'hC3;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       srst;
  logic       d1, dp;
  logic [7:0] d8;
  logic       q1, qp;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  dff_syncasync_reset u_dut1 (
    .clk(clk), .async_reset(arst_n), .sync_reset(srst), .d(d1), .q(q1)
  );

  dff_syncasync_reset #(
    .WIDTH(1), .ASYNC_RST_VAL(1'b0), .SYNC_RST_VAL(1'b1)
  ) u_dutp (
    .clk(clk), .async_reset(arst_n), .sync_reset(srst), .d(dp), .q(qp)
  );

  dff_syncasync_reset #(
    .WIDTH(8), .ASYNC_RST_VAL(A8), .SYNC_RST_VAL(S8)
  ) u_dut8 (
    .clk(clk), .async_reset(arst_n), .sync_reset(srst), .d(d8), .q(q8)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] trk_vals [3];
  logic [7:0] prev8;
  logic       e1, ep;
  logic [7:0] e8;
  int         rel;
  logic       c0, arst_chg;

  initial begin
    trk_vals[0] = 8'hA5;
    trk_vals[1] = 8'h3C;
    trk_vals[2] = 8'hFF;

    // Power-up: async reset held low while clk runs with d=1.
    arst_n = 1'b1; srst = 1'b0; d1 = 1'b1; dp = 1'b1; d8 = 8'hFF;
    #2 arst_n = 1'b0;
    #1;
    check_eq("por_q1", q1, 0);
    check_eq("por_qp", qp, 0);
    check_eq("por_q8", q8, A8);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("por_hold_q1", q1, 0);
      check_eq("por_hold_q8", q8, A8);
    end
    @(negedge clk); arst_n = 1'b1; #1;
    check_eq("rel_nochange_q1", q1, 0);
    for (int k = 1; k <= SYNC_LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k <= SYNC_LAT) begin
        check_eq("rel_wait_q1", q1, 0);
      end else begin
        check_eq("rel_q1", q1, 1);
        check_eq("rel_qp", qp, 1);
        check_eq("rel_q8", q8, 8'hFF);
      end
    end

    // Async assert 5 ns after a rising edge.
    @(posedge clk); #5 arst_n = 1'b0; #1;
    check_eq("amid_q1", q1, 0);
    check_eq("amid_q8", q8, A8);
    srst = 1'b1;
    @(posedge clk); #1;
    check_eq("amid_hold_q1", q1, 0);
    check_eq("amid_hold_qp", qp, 0);
    srst = 1'b0;
    @(negedge clk); arst_n = 1'b1;
    repeat (SYNC_LAT + 1) @(posedge clk);
    #1;
    check_eq("arel_q1", q1, 1);
    check_eq("arel_q8", q8, 8'hFF);

    // Synchronous reset with d=1.
    @(negedge clk); srst = 1'b1;
    @(posedge clk); #1;
    check_eq("srst_q1", q1, 0);
    check_eq("srst_qp", qp, 1);
    check_eq("srst_q8", q8, S8);
    @(negedge clk); srst = 1'b0;
    @(posedge clk); #1;
    check_eq("srst_rel_q1", q1, 1);
    check_eq("srst_rel_q8", q8, 8'hFF);
    // sync_reset pulse and d glitch between edges must not reach q.
    #2 srst = 1'b1;
    #3 srst = 1'b0; d1 = 1'b0; d8 = 8'h00;
    #3;
    check_eq("dmid_q1", q1, 1);
    check_eq("dmid_q8", q8, 8'hFF);
    d1 = 1'b1; d8 = 8'hFF;
    @(posedge clk); #1;
    check_eq("pulse_q1", q1, 1);
    check_eq("pulse_q8", q8, 8'hFF);

    // Priority: async low beats sync high.
    @(negedge clk); arst_n = 1'b0; srst = 1'b1; #1;
    check_eq("pri_qp", qp, 0);
    @(posedge clk); #1;
    check_eq("pri_edge_qp", qp, 0);
    check_eq("pri_edge_q8", q8, A8);
    @(negedge clk); arst_n = 1'b1;
    repeat (SYNC_LAT + 1) @(posedge clk);
    #1;
    check_eq("pri_rel_qp", qp, 1);
    check_eq("pri_rel_q1", q1, 0);
    check_eq("pri_rel_q8", q8, S8);
    @(negedge clk); srst = 1'b0;
    @(posedge clk); #1;

    // 8-bit data tracking, one clock latency.
    prev8 = 8'hFF;
    check_eq("trk_start_q8", q8, prev8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d8 = trk_vals[i]; #1;
      check_eq("trk_pre_q8", q8, prev8);
      @(posedge clk); #1;
      check_eq("trk_q8", q8, trk_vals[i]);
      prev8 = trk_vals[i];
    end

    // Free-running stress on a half-ns grid so no input change meets a clk edge.
    @(negedge clk);
    arst_n = 1'b0; srst = 1'b0; d1 = 1'b0; dp = 1'b1; d8 = 8'h96;
    e1 = 1'b0; ep = 1'b0; e8 = A8; rel = 0;
    @(posedge clk); #0.5;
    for (int n = 0; n < 3000; n++) begin
      arst_chg = 1'b0;
      if (n % 23 == 0) begin
        d1 = ~d1; dp = ~dp; d8 = ~d8;
      end
      if (n % 113 == 0) srst = ~srst;
      if (n % 547 == 0) begin
        arst_n = ~arst_n; arst_chg = 1'b1;
      end
      #0.25;
      if (!arst_n) begin
        e1 = 1'b0; ep = 1'b0; e8 = A8; rel = 0;
      end
      if (arst_chg) begin
        check_eq("stress_arst_q1", q1, e1);
        check_eq("stress_arst_qp", qp, ep);
        check_eq("stress_arst_q8", q8, e8);
      end
      c0 = clk;
      #0.5;
      if (!c0 && clk) begin
        if (arst_n) begin
          if (rel < SYNC_LAT) begin
            rel++;
          end else begin
            e1 = srst ? 1'b0 : d1;
            ep = srst ? 1'b1 : dp;
            e8 = srst ? S8 : d8;
          end
        end
        check_eq("stress_clk_q1", q1, e1);
        check_eq("stress_clk_qp", qp, ep);
        check_eq("stress_clk_q8", q8, e8);
      end
      #0.25;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
